// File: rtl/iob_eth_tx_buf_reader.sv
// Streams a frame out of the TX buffer's registered read port as
// valid/ready bytes, hiding read latency with a 2-entry skid.
// Ports: clk, rst_n; start/base_addr/len/abort control; busy/done status;
//        mem_rd_en/mem_addr/mem_data buffer read port;
//        tx_data/tx_valid/tx_last/tx_ready byte stream.
module iob_eth_tx_buf_reader #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   input  logic              tx_ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   iss_q, iss_d;
   // dv_q: a read was issued last cycle, its data is on mem_data now
   logic              dv_q, dv_d;
   logic              dl_q, dl_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              rp_q, rp_d;
   logic              wp_q, wp_d;
   logic [DATA_W-1:0] sk_data_q [2];
   logic              sk_last_q [2];

   logic       issue;
   logic       push;
   logic       pop;
   logic [2:0] occ;

   assign tx_valid = (cnt_q != 2'd0);
   assign tx_data  = sk_data_q[rp_q];
   assign tx_last  = tx_valid & sk_last_q[rp_q];

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign mem_addr  = addr_q;
   assign mem_rd_en = issue;

   // abort wins over a transfer in the same cycle
   assign pop  = tx_valid & tx_ready & ~abort;
   assign push = dv_q & (state_q == S_RUN) & ~abort;

   // Occupancy after this cycle's pop, counting the read whose data is
   // arriving now; a new read is allowed only while that stays below 2.
   assign occ = 3'(cnt_q) + 3'(dv_q) - 3'(pop);

   assign issue = (state_q == S_RUN) && !abort &&
                  (iss_q < len_q) && (occ < 3'd2);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      addr_d  = issue ? addr_q + 1'b1 : addr_q;
      iss_d   = issue ? iss_q + ONE : iss_q;
      dv_d    = issue;
      dl_d    = (iss_q + ONE == len_q);
      cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
      rp_d    = rp_q ^ pop;
      wp_d    = wp_q ^ push;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               iss_d   = '0;
               len_d   = (len > FULL) ? FULL : len;
               state_d = (len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
               dv_d    = 1'b0;
               cnt_d   = 2'd0;
               rp_d    = 1'b0;
               wp_d    = 1'b0;
            end else if (pop && tx_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         dv_q    <= 1'b0;
         dl_q    <= 1'b0;
         cnt_q   <= 2'd0;
         rp_q    <= 1'b0;
         wp_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         dv_q    <= dv_d;
         dl_q    <= dl_d;
         cnt_q   <= cnt_d;
         rp_q    <= rp_d;
         wp_q    <= wp_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_data_q[0] <= '0;
         sk_data_q[1] <= '0;
         sk_last_q[0] <= 1'b0;
         sk_last_q[1] <= 1'b0;
      end else if (push) begin
         sk_data_q[wp_q] <= mem_data;
         sk_last_q[wp_q] <= dl_q;
      end
   end

endmodule

// File: tb/tb_iob_eth_tx_buf_reader.sv
// Randomized self-checking bench for iob_eth_tx_buf_reader.
// Expected streams come from a buffer-address model of each frame.
module tb_iob_eth_tx_buf_reader;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   len = '0;
   logic          abort = 1'b0;
   logic          busy, done, mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data = '0;
   logic [DW-1:0] tx_data;
   logic          tx_valid, tx_last;
   logic          tx_ready = 1'b0;

   int checks = 0;
   int passed = 0;

   logic [DW-1:0] bufm [DEPTH];

   logic [DW-1:0] got_data [$];
   logic          got_last [$];
   int            addrs [$];
   int first_valid, first_rd, done_cnt, done_cyc, last_cnt;
   int stab_err, maxout, timed_out;
   logic busy_at_done, busy_after;

   iob_eth_tx_buf_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .base_addr(base_addr), .len(len), .abort(abort),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   // registered read port of the TX buffer
   always @(posedge clk) if (mem_rd_en) mem_data <= bufm[mem_addr];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic fill_rand();
      for (int i = 0; i < DEPTH; i++) bufm[i] = DW'($urandom);
   endtask

   task automatic fill_inc();
      for (int i = 0; i < DEPTH; i++) bufm[i] = DW'(i);
   endtask

   // expected frame: bytes bufm[(b+i) mod DEPTH], len saturated to DEPTH
   function automatic int frame_errs(int b, int l);
      int n = (l > DEPTH) ? DEPTH : l;
      int e = 0;
      if (got_data.size() != n) e++;
      for (int i = 0; i < n && i < got_data.size(); i++) begin
         if (got_data[i] !== bufm[(b + i) % DEPTH]) e++;
         if (got_last[i] !== (i == n - 1)) e++;
      end
      return e;
   endfunction

   task automatic send(input int b, input int l, input logic r);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = AW'(b);
      len = (AW+1)'(l);
      tx_ready = r;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_collect(input int mode, input int sp1,
                              input int sp2, input int budget);
      bit pv = 0;
      bit fin = 0;
      logic [DW-1:0] pd = '0;
      logic pl = 1'b0;
      int rd_tot = 0;
      int pop_tot = 0;
      bit pat [6] = '{1, 0, 0, 1, 0, 1};
      got_data.delete(); got_last.delete(); addrs.delete();
      first_valid = -1; first_rd = -1; done_cnt = 0; done_cyc = -1;
      last_cnt = 0; stab_err = 0; maxout = 0; timed_out = 0;
      busy_at_done = 1'bx; busy_after = 1'bx;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         if (mem_rd_en) begin
            addrs.push_back(int'(mem_addr));
            rd_tot++;
            if (first_rd < 0) first_rd = c;
         end
         if (tx_valid && first_valid < 0) first_valid = c;
         if (pv && (!tx_valid || tx_data !== pd || tx_last !== pl))
            stab_err++;
         if (tx_valid && tx_ready) begin
            got_data.push_back(tx_data);
            got_last.push_back(tx_last);
            pop_tot++;
            if (tx_last) last_cnt++;
         end
         if (rd_tot - pop_tot > maxout) maxout = rd_tot - pop_tot;
         pv = tx_valid && !tx_ready;
         pd = tx_data;
         pl = tx_last;
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               busy_at_done = busy;
            end
         end
         if (done_cyc > 0 && c == done_cyc + 1) begin
            busy_after = busy;
            fin = 1;
            break;
         end
         @(posedge clk); #1;
         start = (c + 1 == sp1) || (c + 1 == sp2);
         base_addr = AW'(9);
         len = (AW+1)'(3);
         if (mode == 0) tx_ready = 1'b1;
         else if (c < 6) tx_ready = pat[c];
         else tx_ready = 1'($urandom_range(0, 1));
      end
      if (!fin) timed_out = 1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({busy, done, mem_rd_en, tx_valid, tx_last, mem_addr, tx_data} !== '0)
         $display("FAIL reset_outputs: got %b want 0",
                  {busy, done, mem_rd_en, tx_valid, tx_last, mem_addr, tx_data});
      else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      fill_inc();
      send(0, 4, 1'b1);
      run_collect(0, 0, 0, 30);
      checks++;
      if (timed_out !== 0) $display("FAIL basic_timeout: no done");
      else passed++;
      checks++;
      if (first_rd !== 1) $display("FAIL basic_rd_lat: got %0d want 1", first_rd);
      else passed++;
      checks++;
      if (first_valid !== 3)
         $display("FAIL basic_valid_lat: got %0d want 3", first_valid);
      else passed++;
      checks++;
      if (frame_errs(0, 4) !== 0)
         $display("FAIL basic_data: got %0d errors want 0", frame_errs(0, 4));
      else passed++;
      checks++;
      if (done_cyc !== 7 || done_cnt !== 1)
         $display("FAIL basic_done: cyc %0d cnt %0d want 7 1", done_cyc, done_cnt);
      else passed++;
      checks++;
      if (busy_at_done !== 1'b1 || busy_after !== 1'b0)
         $display("FAIL basic_busy: %b %b want 1 0", busy_at_done, busy_after);
      else passed++;
   endtask

   task automatic test_wrap();
      int exp_a [5] = '{14, 15, 0, 1, 2};
      int e = 0;
      fill_rand();
      send(14, 5, 1'b1);
      run_collect(0, 0, 0, 30);
      if (addrs.size() != 5) e++;
      for (int i = 0; i < 5 && i < addrs.size(); i++)
         if (addrs[i] != exp_a[i]) e++;
      checks++;
      if (e !== 0) $display("FAIL wrap_addr: got %0d errors want 0", e);
      else passed++;
      checks++;
      if (frame_errs(14, 5) !== 0)
         $display("FAIL wrap_data: got %0d errors want 0", frame_errs(14, 5));
      else passed++;
   endtask

   task automatic test_backpressure();
      int b;
      for (int k = 0; k < 4; k++) begin
         fill_rand();
         b = int'($urandom_range(0, DEPTH - 1));
         send(b, 8, 1'b1);
         run_collect(1, 0, 0, 200);
         checks++;
         if (frame_errs(b, 8) !== 0 || timed_out !== 0)
            $display("FAIL bp_data: got %0d errors to %0d want 0",
                     frame_errs(b, 8), timed_out);
         else passed++;
         checks++;
         if (stab_err !== 0)
            $display("FAIL bp_stable: got %0d changes want 0", stab_err);
         else passed++;
         checks++;
         if (maxout > 2)
            $display("FAIL bp_outstanding: got %0d want <=2", maxout);
         else passed++;
         checks++;
         if (done_cnt !== 1 || last_cnt !== 1)
            $display("FAIL bp_done: done %0d last %0d want 1 1", done_cnt, last_cnt);
         else passed++;
      end
   endtask

   task automatic test_len_zero();
      send(3, 0, 1'b1);
      run_collect(0, 0, 0, 10);
      checks++;
      if (first_valid !== -1 || addrs.size() !== 0)
         $display("FAIL zero_no_beats: valid %0d reads %0d want -1 0",
                  first_valid, addrs.size());
      else passed++;
      checks++;
      if (done_cyc !== 1 || done_cnt !== 1)
         $display("FAIL zero_done: cyc %0d cnt %0d want 1 1", done_cyc, done_cnt);
      else passed++;
   endtask

   task automatic test_saturate();
      int b;
      fill_rand();
      b = int'($urandom_range(0, DEPTH - 1));
      send(b, DEPTH + 5, 1'b1);
      run_collect(0, 0, 0, 60);
      checks++;
      if (got_data.size() !== DEPTH)
         $display("FAIL sat_count: got %0d want %0d", got_data.size(), DEPTH);
      else passed++;
      checks++;
      if (frame_errs(b, DEPTH + 5) !== 0)
         $display("FAIL sat_data: got %0d errors want 0", frame_errs(b, DEPTH + 5));
      else passed++;
      checks++;
      if (done_cyc !== DEPTH + 3)
         $display("FAIL sat_throughput: done %0d want %0d", done_cyc, DEPTH + 3);
      else passed++;
   endtask

   task automatic test_start_busy();
      int b;
      fill_rand();
      b = int'($urandom_range(0, DEPTH - 1));
      send(b, 6, 1'b1);
      // second stray start lands in the DONE cycle (len+3)
      run_collect(0, 2, 9, 30);
      checks++;
      if (frame_errs(b, 6) !== 0 || done_cnt !== 1)
         $display("FAIL busy_start: errors %0d done %0d want 0 1",
                  frame_errs(b, 6), done_cnt);
      else passed++;
      checks++;
      if (busy_after !== 1'b0)
         $display("FAIL done_start: busy %b want 0", busy_after);
      else passed++;
   endtask

   task automatic test_abort();
      int beats = 0;
      int dn = 0;
      int b;
      logic v5 = 1'b0;
      logic v6 = 1'b1;
      logic b6 = 1'b1;
      fill_rand();
      b = int'($urandom_range(0, DEPTH - 1));
      send(b, 10, 1'b1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (tx_valid && tx_ready && !abort) beats++;
         if (done) dn++;
         if (c == 5) v5 = tx_valid;
         if (c == 6) begin
            v6 = tx_valid;
            b6 = busy;
         end
         @(posedge clk); #1;
         abort = (c + 1 == 5);
      end
      checks++;
      if (v5 !== 1'b1 || v6 !== 1'b0 || b6 !== 1'b0)
         $display("FAIL abort_stop: v5 %b v6 %b busy6 %b want 1 0 0", v5, v6, b6);
      else passed++;
      checks++;
      if (beats !== 2 || dn !== 0)
         $display("FAIL abort_beats: beats %0d done %0d want 2 0", beats, dn);
      else passed++;
      fill_rand();
      b = int'($urandom_range(0, DEPTH - 1));
      send(b, 2, 1'b1);
      run_collect(0, 0, 0, 20);
      checks++;
      if (frame_errs(b, 2) !== 0 || done_cnt !== 1)
         $display("FAIL abort_restart: errors %0d done %0d want 0 1",
                  frame_errs(b, 2), done_cnt);
      else passed++;
   endtask

   task automatic test_reset_mid();
      logic v7;
      fill_rand();
      send(5, 10, 1'b1);
      repeat (7) @(negedge clk);
      v7 = tx_valid;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (v7 !== 1'b1 ||
          {busy, done, mem_rd_en, tx_valid, tx_last, mem_addr, tx_data} !== '0)
         $display("FAIL reset_mid: beat5 %b outputs %b want 1 0", v7,
                  {busy, done, mem_rd_en, tx_valid, tx_last, mem_addr, tx_data});
      else passed++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_idle: busy %b done %b want 0 0", busy, done);
      else passed++;
      fill_inc();
      send(0, 4, 1'b1);
      run_collect(0, 0, 0, 30);
      checks++;
      if (frame_errs(0, 4) !== 0 || first_valid !== 3 || done_cyc !== 7)
         $display("FAIL reset_restart: errors %0d valid %0d done %0d want 0 3 7",
                  frame_errs(0, 4), first_valid, done_cyc);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_len_zero();
      test_saturate();
      test_start_busy();
      test_abort();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
